// File: rtl/feeder_pkg.sv
// Shared definitions for the systolic array operand feeder.
package feeder_pkg;

    localparam int DATA_W = 8;

    // wr_sel encoding: which operand buffer a host write targets
    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        STREAM,
        DRAIN,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/operand_buf.sv
// SIZE x SIZE operand register file: one write port, full-array combinational read.
// Contents are deliberately not reset; the host reloads matrices as needed.
module operand_buf
    import feeder_pkg::*;
#(
    parameter int SIZE = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(SIZE)-1:0]  row,
    input  logic [$clog2(SIZE)-1:0]  col,
    input  logic [DATA_W-1:0]        data,
    output logic [DATA_W-1:0]        rd [SIZE-1:0][SIZE-1:0]
);

    logic [DATA_W-1:0] mem [SIZE-1:0][SIZE-1:0];

    // Element write
    always_ff @(posedge clk) begin
        if (we) begin
            mem[row][col] <= data;
        end
    end

    assign rd = mem;

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for a SIZE x SIZE systolic MAC array: buffers A and B, then
// streams diagonally skewed wavefronts and sequences load/mult/acc enables.
// Optional macro FEEDER_ERR_EN enables the sticky protocol error flag.
module systolic_feeder
    import feeder_pkg::*;
#(
    parameter int SIZE         = 4,
    parameter int DRAIN_CYCLES = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     wr_sel,
    input  logic [$clog2(SIZE)-1:0]  wr_row,
    input  logic [$clog2(SIZE)-1:0]  wr_col,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        a_out [SIZE-1:0],
    output logic [DATA_W-1:0]        b_out [SIZE-1:0],
    output logic                     load_en,
    output logic                     mult_en,
    output logic                     acc_en,
    output logic                     err
);

    localparam int IDX_W       = $clog2(SIZE);
    localparam int STREAM_LAST = 3*SIZE - 3;
    localparam int CNT_MAX     = (3*SIZE - 2 > DRAIN_CYCLES) ? 3*SIZE - 2 : DRAIN_CYCLES;
    localparam int CNT_W       = $clog2(CNT_MAX + 1);

    feeder_state_t     state, state_nxt;
    logic [CNT_W-1:0]  t, t_nxt;

    logic [DATA_W-1:0] a_mem [SIZE-1:0][SIZE-1:0];
    logic [DATA_W-1:0] b_mem [SIZE-1:0][SIZE-1:0];

    logic              busy_nxt, done_nxt, load_nxt, mult_nxt, acc_nxt;
    logic [DATA_W-1:0] a_nxt [SIZE-1:0];
    logic [DATA_W-1:0] b_nxt [SIZE-1:0];

    logic              wr_ok, we_a, we_b;

    assign wr_ok = wr_en && !busy;
    assign we_a  = wr_ok && (wr_sel == SEL_A);
    assign we_b  = wr_ok && (wr_sel == SEL_B);

    operand_buf #(.SIZE(SIZE)) u_buf_a (
        .clk  (clk),
        .we   (we_a),
        .row  (wr_row),
        .col  (wr_col),
        .data (wr_data),
        .rd   (a_mem)
    );

    operand_buf #(.SIZE(SIZE)) u_buf_b (
        .clk  (clk),
        .we   (we_b),
        .row  (wr_row),
        .col  (wr_col),
        .data (wr_data),
        .rd   (b_mem)
    );

    // Next-state and step counter; the counter is reused for the drain phase
    always_comb begin
        state_nxt = state;
        t_nxt     = t;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                state_nxt = STREAM;
                t_nxt     = '0;
            end
            STREAM: begin
                if (t == CNT_W'(STREAM_LAST)) begin
                    t_nxt     = '0;
                    state_nxt = (DRAIN_CYCLES == 0) ? DONE : DRAIN;
                end else begin
                    t_nxt = t + CNT_W'(1);
                end
            end
            DRAIN: begin
                if (t == CNT_W'(DRAIN_CYCLES - 1)) begin
                    t_nxt     = '0;
                    state_nxt = DONE;
                end else begin
                    t_nxt = t + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                t_nxt     = '0;
            end
            default: begin
                state_nxt = IDLE;
                t_nxt     = '0;
            end
        endcase
    end

    // Output values for the upcoming cycle, derived from the next state so that
    // every output can be registered without adding a cycle of latency
    always_comb begin
        logic [CNT_W-1:0] kk;
        logic [CNT_W-1:0] d;
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
        load_nxt = (state_nxt == CLEAR);
        mult_nxt = (state_nxt == STREAM) || (state_nxt == DRAIN);
        acc_nxt  = (state_nxt == STREAM) || (state_nxt == DRAIN);
        for (int unsigned k = 0; k < SIZE; k++) begin
            a_nxt[k] = '0;
            b_nxt[k] = '0;
            kk       = CNT_W'(k);
            d        = t_nxt - kk;
            if ((state_nxt == STREAM) && (t_nxt >= kk) && (d < CNT_W'(SIZE))) begin
                a_nxt[k] = a_mem[k][d[IDX_W-1:0]];
                b_nxt[k] = b_mem[d[IDX_W-1:0]][k];
            end
        end
    end

    // State, counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            t       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            load_en <= 1'b0;
            mult_en <= 1'b0;
            acc_en  <= 1'b0;
            for (int unsigned k = 0; k < SIZE; k++) begin
                a_out[k] <= '0;
                b_out[k] <= '0;
            end
        end else begin
            state   <= state_nxt;
            t       <= t_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            load_en <= load_nxt;
            mult_en <= mult_nxt;
            acc_en  <= acc_nxt;
            for (int unsigned k = 0; k < SIZE; k++) begin
                a_out[k] <= a_nxt[k];
                b_out[k] <= b_nxt[k];
            end
        end
    end

`ifdef FEEDER_ERR_EN
    // Sticky flag for writes or starts issued while a run is in progress
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err <= 1'b0;
        end else if ((state == IDLE) && start) begin
            err <= 1'b0;
        end else if (busy && (wr_en || start)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// Scoreboard bench for systolic_feeder: stimulus pushes per-cycle expected
// output vectors for each run, a negedge monitor pops them while busy is high.
module tb_systolic_feeder;

    localparam int SIZE  = 4;
    localparam int DRAIN = 1;
    localparam int IW    = $clog2(SIZE);
    localparam int NT    = 3*SIZE - 2;
    localparam int VW    = 5 + 16*SIZE;
    localparam int LAT   = 1 + 1 + NT + DRAIN + 1;
`ifdef FEEDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic           clk, reset, wr_en, wr_sel, start;
    logic [IW-1:0]  wr_row, wr_col;
    logic [7:0]     wr_data;
    logic           busy, done, load_en, mult_en, acc_en, err;
    logic [7:0]     a_out [SIZE-1:0];
    logic [7:0]     b_out [SIZE-1:0];

    systolic_feeder #(.SIZE(SIZE), .DRAIN_CYCLES(DRAIN)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_row  (wr_row),
        .wr_col  (wr_col),
        .wr_data (wr_data),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .a_out   (a_out),
        .b_out   (b_out),
        .load_en (load_en),
        .mult_en (mult_en),
        .acc_en  (acc_en),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0]    ma [SIZE][SIZE];
    logic [7:0]    mb [SIZE][SIZE];
    logic [VW-1:0] q [$];
    bit            exp_err = 1'b0;

    task automatic check(input string nm, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    function automatic logic [8*SIZE-1:0] aflat();
        logic [8*SIZE-1:0] r;
        for (int k = 0; k < SIZE; k++) r[8*k +: 8] = a_out[k];
        return r;
    endfunction

    function automatic logic [8*SIZE-1:0] bflat();
        logic [8*SIZE-1:0] r;
        for (int k = 0; k < SIZE; k++) r[8*k +: 8] = b_out[k];
        return r;
    endfunction

    function automatic logic [VW-1:0] dut_vec();
        return {busy, done, load_en, mult_en, acc_en, aflat(), bflat()};
    endfunction

    // Reference: element A[k][j] reaches row k at step j+k, B[j][k] reaches column k at step j+k
    task automatic push_run();
        logic [7:0]        wa [NT][SIZE];
        logic [7:0]        wb [NT][SIZE];
        logic [8*SIZE-1:0] af, bf;
        for (int t = 0; t < NT; t++)
            for (int k = 0; k < SIZE; k++) begin
                wa[t][k] = 8'h00;
                wb[t][k] = 8'h00;
            end
        for (int k = 0; k < SIZE; k++)
            for (int j = 0; j < SIZE; j++) begin
                wa[j+k][k] = ma[k][j];
                wb[j+k][k] = mb[j][k];
            end
        q.push_back({5'b10100, {(16*SIZE){1'b0}}});
        for (int t = 0; t < NT; t++) begin
            for (int k = 0; k < SIZE; k++) begin
                af[8*k +: 8] = wa[t][k];
                bf[8*k +: 8] = wb[t][k];
            end
            q.push_back({5'b10011, af, bf});
        end
        for (int d = 0; d < DRAIN; d++) q.push_back({5'b10011, {(16*SIZE){1'b0}}});
        q.push_back({5'b11000, {(16*SIZE){1'b0}}});
    endtask

    // Monitor: every busy cycle must match the next expected vector
    always @(negedge clk) begin
        logic [VW-1:0] act, exp;
        if (!reset && busy) begin
            act = dut_vec();
            tests++;
            if (q.size() == 0) begin
                fails++;
                $display("FAIL scoreboard_unexpected got=%h exp=none", act);
            end else begin
                exp = q.pop_front();
                if (act !== exp) begin
                    fails++;
                    $display("FAIL scoreboard got=%h exp=%h", act, exp);
                end
            end
        end
    end

    task automatic wr_idle(input logic sel, input int r, input int c, input logic [7:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_row = IW'(r); wr_col = IW'(c); wr_data = d;
        if (sel) mb[r][c] = d; else ma[r][c] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic run(input bit keep, input bit wr_same, input bit poke, input bit ident);
        int cyc;
        int r, c;
        logic s;
        logic [7:0] d;
        @(negedge clk);
        check("idle_busy", busy, 0);
        if (wr_same) begin
            s = 1'($urandom_range(0, 1));
            r = $urandom_range(0, SIZE-1);
            c = $urandom_range(0, SIZE-1);
            d = 8'($urandom);
            wr_en = 1'b1; wr_sel = s; wr_row = IW'(r); wr_col = IW'(c); wr_data = d;
            if (s) mb[r][c] = d; else ma[r][c] = d;
        end
        start   = 1'b1;
        exp_err = 1'b0;
        push_run();
        cyc = 1;
        while (cyc < LAT + 20) begin
            @(negedge clk);
            cyc++;
            wr_en = 1'b0;
            if (!keep) start = 1'b0;
            if (keep && ERR_EN && cyc == 2) exp_err = 1'b1;
            if (cyc == 2) check("err_clear_on_start", err, 0);
            if (ident && cyc == 3) begin
                check("t0_a_out", aflat(), 32'h00000001);
                check("t0_b_out", bflat(), 32'h00000001);
            end
            if (ident && cyc == 6) begin
                check("t3_a_out", aflat(), 32'h00000000);
                check("t3_b_out", bflat(), 32'h04070A0D);
            end
            if (poke && cyc == 4) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = '0; wr_col = '0; wr_data = 8'hFF;
                if (ERR_EN) exp_err = 1'b1;
            end
            if (poke && cyc == 6) start = 1'b1;
            if (done) break;
        end
        check("latency", cyc, LAT);
        if (!done) q.delete();
        check("err_at_done", err, exp_err);
    endtask

    task automatic reset_mid_stream();
        @(negedge clk);
        start = 1'b1;
        push_run();
        repeat (5) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_outputs", dut_vec(), 0);
        check("midrun_reset_err", err, 0);
        q.delete();
        exp_err = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_no_done", {busy, done}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("post_reset_idle", {busy, done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0;
        wr_row = '0; wr_col = '0; wr_data = '0;
        #2 reset = 1'b1;
        #2;
        check("reset_outputs", dut_vec(), 0);
        check("reset_err", err, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int r = 0; r < SIZE; r++)
            for (int c = 0; c < SIZE; c++) begin
                wr_idle(1'b0, r, c, (r == c) ? 8'd1 : 8'd0);
                wr_idle(1'b1, r, c, 8'(4*r + c + 1));
            end

        run(1'b0, 1'b0, 1'b0, 1'b1);
        run(1'b0, 1'b0, 1'b1, 1'b0);
        run(1'b0, 1'b0, 1'b0, 1'b1);

        reset_mid_stream();
        run(1'b0, 1'b0, 1'b0, 1'b1);

        run(1'b1, 1'b0, 1'b0, 1'b0);
        run(1'b1, 1'b0, 1'b0, 1'b0);
        run(1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) begin
            for (int r = 0; r < SIZE; r++)
                for (int c = 0; c < SIZE; c++) begin
                    wr_idle(1'b0, r, c, 8'($urandom));
                    wr_idle(1'b1, r, c, 8'($urandom));
                end
            run(1'b0, 1'(i % 2), 1'b0, 1'b0);
            run(1'b0, 1'b1, 1'b0, 1'b0);
        end

        @(negedge clk);
        check("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
